// File: rtl/disp7seg_pkg.sv
// Shared constants and the hex glyph table for the multi-digit 7-segment controller.
// Segment patterns here are active-high (bit 0 = a ... bit 6 = g).
package disp7seg_pkg;

    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_DARK = 7'h00;

    typedef enum logic [3:0] {
        REG_DATA      = 4'd0,
        REG_ENABLE    = 4'd1,
        REG_MODE      = 4'd2,
        REG_BLINK     = 4'd3,
        REG_BLINK_DIV = 4'd4,
        REG_STATUS    = 4'd5,
        REG_RAW0      = 4'd8
    } regOffset_e;

    function automatic logic [SEG_W-1:0] hexToSeg(input logic [3:0] nibble);
        logic [SEG_W-1:0] pattern;
        case (nibble)
            4'h0: pattern = 7'h3F;
            4'h1: pattern = 7'h06;
            4'h2: pattern = 7'h5B;
            4'h3: pattern = 7'h4F;
            4'h4: pattern = 7'h66;
            4'h5: pattern = 7'h6D;
            4'h6: pattern = 7'h7D;
            4'h7: pattern = 7'h07;
            4'h8: pattern = 7'h7F;
            4'h9: pattern = 7'h6F;
            4'hA: pattern = 7'h77;
            4'hB: pattern = 7'h7C;
            4'hC: pattern = 7'h39;
            4'hD: pattern = 7'h5E;
            4'hE: pattern = 7'h79;
            default: pattern = 7'h71;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/avalon_displays7seg_multi_if.sv
// Avalon-MM slave bus of the 7-segment controller: word address, full-word writes,
// fixed read latency of one cycle and no waitrequest.
interface avalon_displays7seg_multi_if;
    logic [3:0]  avs_s0_address;
    logic        avs_s0_write;
    logic [31:0] avs_s0_writedata;
    logic        avs_s0_read;
    logic [31:0] avs_s0_readdata;

    modport master (
        output avs_s0_address, avs_s0_write, avs_s0_writedata, avs_s0_read,
        input  avs_s0_readdata
    );

    modport slave (
        input  avs_s0_address, avs_s0_write, avs_s0_writedata, avs_s0_read,
        output avs_s0_readdata
    );
endinterface

// File: rtl/disp7seg_blink_timer.sv
// Blink half-period timer: counts 0..div-1 and toggles the phase on each wrap.
// A zero divider parks the phase at 1 (lit); reload restarts the lit half-period.
module disp7seg_blink_timer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] div_i,
    input  logic        reload_i,
    output logic        phase_o
);

    logic [31:0] count_q, count_d;
    logic        phase_q, phase_d;

    // The >= compare keeps the counter bounded if the divider shrinks mid-count.
    always_comb begin
        count_d = count_q + 32'd1;
        phase_d = phase_q;
        if (reload_i || div_i == 32'd0) begin
            count_d = '0;
            phase_d = 1'b1;
        end else if (count_q >= div_i - 32'd1) begin
            count_d = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
            phase_q <= 1'b1;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/avalon_displays7seg_multi.sv
// Avalon-MM multi-digit 7-segment display controller with hex/raw modes per digit.
// Blinking (BLINK, BLINK_DIV and the timer) exists only when DISP7SEG_BLINK_EN is defined.
module avalon_displays7seg_multi
    import disp7seg_pkg::*;
#(
    parameter int          NUM_DIGITS        = 8,
    parameter int          SEG_ACTIVE_LOW    = 1,
    parameter logic [31:0] BLINK_DIV_DEFAULT = 32'd25000000
) (
    input  logic                           clk_clk,
    input  logic                           reset_reset_n,
    avalon_displays7seg_multi_if.slave     avs_s0,
    output logic [SEG_W*NUM_DIGITS-1:0]    coe_seg
);

    localparam logic [7:0]  DIG_MASK  = 8'((16'd1 << NUM_DIGITS) - 16'd1);
    localparam logic [31:0] DATA_MASK = 32'((64'd1 << (4 * NUM_DIGITS)) - 64'd1);
    localparam logic [SEG_W*NUM_DIGITS-1:0] SEG_ALL_DARK = {(SEG_W*NUM_DIGITS){SEG_ACTIVE_LOW != 0}};

    logic [31:0]                 data_q;
    logic [7:0]                  enable_q;
    logic [7:0]                  mode_q;
    logic [SEG_W-1:0]            raw_q [8];
    logic [31:0]                 readData_q, readData_d;
    logic [SEG_W*NUM_DIGITS-1:0] seg_q, seg_d;
    logic [SEG_W-1:0]            pattern;
    logic [3:0]                  addr;
    logic [2:0]                  rawIdx;
    logic                        rawValid;
    logic                        wrEn;
    logic                        blinkPhase;
    logic [7:0]                  blink_q;
    logic [31:0]                 blinkDiv_q;

    assign addr     = avs_s0.avs_s0_address;
    assign wrEn     = avs_s0.avs_s0_write;
    assign rawIdx   = addr[2:0];
    assign rawValid = addr[3] && (int'(rawIdx) < NUM_DIGITS);

`ifdef DISP7SEG_BLINK_EN
    localparam logic BLINK_BUILT = 1'b1;
    logic divReload;

    assign divReload = wrEn && (addr == REG_BLINK_DIV);

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            blink_q    <= '0;
            blinkDiv_q <= BLINK_DIV_DEFAULT;
        end else if (wrEn) begin
            if (addr == REG_BLINK)
                blink_q <= avs_s0.avs_s0_writedata[7:0] & DIG_MASK;
            if (divReload)
                blinkDiv_q <= avs_s0.avs_s0_writedata;
        end
    end

    disp7seg_blink_timer u_blinkTimer (
        .clk_i    (clk_clk),
        .rst_ni   (reset_reset_n),
        .div_i    (blinkDiv_q),
        .reload_i (divReload),
        .phase_o  (blinkPhase)
    );
`else
    localparam logic BLINK_BUILT = 1'b0;

    assign blink_q    = '0;
    assign blinkDiv_q = '0;
    assign blinkPhase = 1'b1;
`endif

    // Reads see only registered state, so a same-cycle write returns the old value.
    always_comb begin
        readData_d = '0;
        if (addr[3]) begin
            if (rawValid)
                readData_d = 32'(raw_q[rawIdx]);
        end else begin
            case (addr)
                REG_DATA:      readData_d = data_q;
                REG_ENABLE:    readData_d = {24'd0, enable_q};
                REG_MODE:      readData_d = {24'd0, mode_q};
                REG_BLINK:     readData_d = {24'd0, blink_q};
                REG_BLINK_DIV: readData_d = blinkDiv_q;
                REG_STATUS:    readData_d = {22'd0, blinkPhase, BLINK_BUILT, 4'd0, 4'(NUM_DIGITS)};
                default:       readData_d = '0;
            endcase
        end
    end

    always_comb begin
        seg_d   = '0;
        pattern = SEG_DARK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            pattern = SEG_DARK;
            if (enable_q[i]) begin
                if (blink_q[i] && !blinkPhase)
                    pattern = SEG_DARK;
                else if (mode_q[i])
                    pattern = raw_q[i];
                else
                    pattern = hexToSeg(data_q[4*i +: 4]);
            end
            if (SEG_ACTIVE_LOW != 0)
                pattern = ~pattern;
            seg_d[SEG_W*i +: SEG_W] = pattern;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            data_q     <= '0;
            enable_q   <= DIG_MASK;
            mode_q     <= '0;
            for (int i = 0; i < 8; i++)
                raw_q[i] <= '0;
            readData_q <= '0;
            seg_q      <= SEG_ALL_DARK;
        end else begin
            if (wrEn) begin
                if (rawValid) begin
                    raw_q[rawIdx] <= avs_s0.avs_s0_writedata[SEG_W-1:0];
                end else begin
                    case (addr)
                        REG_DATA:   data_q   <= avs_s0.avs_s0_writedata & DATA_MASK;
                        REG_ENABLE: enable_q <= avs_s0.avs_s0_writedata[7:0] & DIG_MASK;
                        REG_MODE:   mode_q   <= avs_s0.avs_s0_writedata[7:0] & DIG_MASK;
                        default:    ;
                    endcase
                end
            end
            if (avs_s0.avs_s0_read)
                readData_q <= readData_d;
            seg_q <= seg_d;
        end
    end

    assign avs_s0.avs_s0_readdata = readData_q;
    assign coe_seg                = seg_q;

endmodule

// File: tb/tb_avalon_displays7seg_multi.sv
// Directed self-checking bench for avalon_displays7seg_multi (8 digits, active-low segments).
// Blink expectations follow whether DISP7SEG_BLINK_EN is defined for this build.
module tb_avalon_displays7seg_multi;

    localparam int ND = 8;

`ifdef DISP7SEG_BLINK_EN
    localparam bit          BLINK_ON   = 1'b1;
    localparam logic [31:0] EXP_STATUS = 32'h0000_0308;
`else
    localparam bit          BLINK_ON   = 1'b0;
    localparam logic [31:0] EXP_STATUS = 32'h0000_0208;
`endif

    logic              clk = 1'b0;
    logic              resetN;
    logic [7*ND-1:0]   seg;
    logic [31:0]       rdData;
    int                checkCount = 0;
    int                failCount  = 0;

    avalon_displays7seg_multi_if busIf ();

    avalon_displays7seg_multi #(
        .NUM_DIGITS        (ND),
        .SEG_ACTIVE_LOW    (1),
        .BLINK_DIV_DEFAULT (32'd25000000)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (resetN),
        .avs_s0        (busIf),
        .coe_seg       (seg)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] digitOf(input int i);
        return 32'(seg[7*i +: 7]);
    endfunction

    // One bus cycle driven between falling edges; the DUT samples it on the rising edge in between.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [3:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        busIf.avs_s0_write     = wr;
        busIf.avs_s0_read      = rd;
        busIf.avs_s0_address   = addr;
        busIf.avs_s0_writedata = wdata;
        @(negedge clk);
        busIf.avs_s0_write = 1'b0;
        busIf.avs_s0_read  = 1'b0;
    endtask

    task automatic busWrite(input logic [3:0] addr, input logic [31:0] wdata);
        applyStimulus(1'b1, 1'b0, addr, wdata);
    endtask

    task automatic busRead(input logic [3:0] addr, output logic [31:0] data);
        applyStimulus(1'b0, 1'b1, addr, 32'd0);
        data = busIf.avs_s0_readdata;
    endtask

    initial begin
        busIf.avs_s0_write     = 1'b0;
        busIf.avs_s0_read      = 1'b0;
        busIf.avs_s0_address   = 4'd0;
        busIf.avs_s0_writedata = 32'd0;
        resetN                 = 1'b0;

        // Reset and first frame after release
        repeat (3) @(negedge clk);
        checkOutput("reset_dark_d0", digitOf(0), 32'h7F);
        checkOutput("reset_readdata", busIf.avs_s0_readdata, 32'h0);
        resetN = 1'b1;
        @(negedge clk);
        for (int i = 0; i < ND; i++)
            checkOutput($sformatf("release_zero_d%0d", i), digitOf(i), 32'h40);
        busRead(4'd1, rdData);
        checkOutput("reset_enable", rdData, 32'h0000_00FF);
        busRead(4'd5, rdData);
        checkOutput("reset_status", rdData, EXP_STATUS);

        // Hex decode with exact two-edge latency
        busWrite(4'd0, 32'h89AB_CDE7);
        checkOutput("hex_latency_d0", digitOf(0), 32'h40);
        @(negedge clk);
        checkOutput("hex_d0", digitOf(0), 32'h78);
        checkOutput("hex_d1", digitOf(1), 32'h06);
        checkOutput("hex_d2", digitOf(2), 32'h21);
        checkOutput("hex_d3", digitOf(3), 32'h46);
        checkOutput("hex_d4", digitOf(4), 32'h03);
        checkOutput("hex_d5", digitOf(5), 32'h08);
        checkOutput("hex_d6", digitOf(6), 32'h10);
        checkOutput("hex_d7", digitOf(7), 32'h00);
        busRead(4'd0, rdData);
        checkOutput("data_readback", rdData, 32'h89AB_CDE7);

        // Raw mode on digit 2, with a read of RAW[2] in the same cycle as its write
        busWrite(4'd2, 32'h0000_0004);
        applyStimulus(1'b1, 1'b1, 4'd10, 32'h0000_0049);
        checkOutput("raw_rw_same_cycle", busIf.avs_s0_readdata, 32'h0);
        @(negedge clk);
        checkOutput("raw_d2", digitOf(2), 32'h36);
        checkOutput("raw_d3_unchanged", digitOf(3), 32'h46);
        checkOutput("raw_d0_unchanged", digitOf(0), 32'h78);
        busRead(4'd10, rdData);
        checkOutput("raw2_readback", rdData, 32'h49);
        busRead(4'd2, rdData);
        checkOutput("mode_readback", rdData, 32'h04);

        // Blinking digit 0 with a half-period of 4 clocks
        busWrite(4'd3, 32'h0000_0001);
        busRead(4'd3, rdData);
        checkOutput("blink_readback", rdData, BLINK_ON ? 32'h01 : 32'h00);
        busWrite(4'd4, 32'd4);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checkOutput($sformatf("blink_d0_k%0d", k), digitOf(0),
                        (BLINK_ON && (((k - 1) / 4) % 2 == 1)) ? 32'h7F : 32'h78);
            checkOutput($sformatf("blink_d1_k%0d", k), digitOf(1), 32'h06);
        end
        busWrite(4'd4, 32'd0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checkOutput($sformatf("div0_lit_k%0d", k), digitOf(0), 32'h78);
        end
        busRead(4'd4, rdData);
        checkOutput("div0_readback", rdData, 32'h0);

        // Reset asserted during the dark half-period and during a read
        busWrite(4'd4, 32'd4);
        repeat (5) @(negedge clk);
        checkOutput("midblink_dark_d0", digitOf(0), BLINK_ON ? 32'h7F : 32'h78);
        resetN               = 1'b0;
        busIf.avs_s0_read    = 1'b1;
        busIf.avs_s0_address = 4'd0;
        repeat (2) @(negedge clk);
        busIf.avs_s0_read = 1'b0;
        resetN            = 1'b1;
        checkOutput("midread_readdata", busIf.avs_s0_readdata, 32'h0);
        @(negedge clk);
        checkOutput("midblink_release_d0", digitOf(0), 32'h40);
        busRead(4'd4, rdData);
        checkOutput("midblink_div_default", rdData, BLINK_ON ? 32'd25000000 : 32'd0);
        busRead(4'd5, rdData);
        checkOutput("midblink_status", rdData, EXP_STATUS);
        busRead(4'd3, rdData);
        checkOutput("midblink_blink_cleared", rdData, 32'h0);

        // Global disable and unmapped offsets
        busWrite(4'd1, 32'h0000_0000);
        checkOutput("disable_latency_d0", digitOf(0), 32'h40);
        @(negedge clk);
        for (int i = 0; i < ND; i++)
            checkOutput($sformatf("disabled_d%0d", i), digitOf(i), 32'h7F);
        busWrite(4'd6, 32'hDEAD_BEEF);
        busRead(4'd6, rdData);
        checkOutput("unmapped6_read", rdData, 32'h0);
        busRead(4'd7, rdData);
        checkOutput("unmapped7_read", rdData, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
